// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch sequencer: reset/enable levels, stall vectors and FSM encodings.
package fetch_ctrl_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int unsigned           InstAddrW = 32;
  localparam logic [InstAddrW-1:0] ZeroWord  = '0;

  // Stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam logic [5:0] StallNone  = 6'b000000;
  localparam logic [5:0] StallFetch = 6'b000011;
  localparam logic [5:0] StallId    = 6'b000111;
  localparam logic [5:0] StallEx    = 6'b001111;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  function automatic logic [5:0] stall_vec(input logic ex, input logic id, input logic pend);
    if (ex)        return StallEx;
    else if (id)   return StallId;
    else if (pend) return StallFetch;
    else           return StallNone;
  endfunction

endpackage

// File: rtl/stall_enc.sv
// Priority encoder: EX stall over ID stall over an outstanding fetch.
module stall_enc
  import fetch_ctrl_pkg::*;
(
  input  logic       stallreq_ex,
  input  logic       stallreq_id,
  input  logic       fetch_pending,
  output logic [5:0] stall
);

  always_comb begin
    stall = stall_vec(stallreq_ex, stallreq_id, fetch_pending);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: PC, ROM request handshake, branch redirect and stall vector.
// Build option DELAY_SLOT_EN: keep the post-branch instruction (no IF squash).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              inst_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              inst_req,
  output logic [5:0]        stall,
  output logic              flush_if
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_target;

  logic w_active;
  logic w_stalled;
  logic w_accept;
  logic w_branch_take;
  logic w_fetch_pending;

  assign w_active        = (r_state != StIdle);
  assign w_stalled       = stallreq_id | stallreq_ex;
  assign w_accept        = w_active & inst_ack & ~w_stalled;
  assign w_branch_take   = branch_flag & ~w_stalled;
  assign w_fetch_pending = w_active & ~inst_ack;

  assign pc       = r_pc;
  assign ce       = w_active ? ChipEnable : ChipDisable;
  assign inst_req = w_active;

  // A same-cycle branch wins over an older latched redirect
  assign w_pc_nxt = w_branch_take    ? branch_target :
                    r_redirect_valid ? r_redirect_target :
                                       r_pc + ADDR_W'(4);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: w_state_nxt = StReq;
      StReq, StWait: begin
        if (w_accept)      w_state_nxt = StReq;
        else if (inst_ack) w_state_nxt = StHold;
        else               w_state_nxt = StWait;
      end
      StHold: if (w_accept) w_state_nxt = StReq;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state           <= StIdle;
      r_pc              <= RESET_PC;
      r_redirect_valid  <= 1'b0;
      r_redirect_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pc             <= w_pc_nxt;
        r_redirect_valid <= 1'b0;
      end else if (w_branch_take) begin
        r_redirect_valid  <= 1'b1;
        r_redirect_target <= branch_target;
      end
    end
  end

`ifdef DELAY_SLOT_EN
  assign flush_if = 1'b0;
`else
  assign flush_if = w_accept & (w_branch_take | r_redirect_valid);
`endif

  stall_enc u_stall_enc (
    .stallreq_ex   (stallreq_ex),
    .stallreq_id   (stallreq_id),
    .fetch_pending (w_fetch_pending),
    .stall         (stall)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl plus hand-written latency/priority sequences.
module tb_fetch_ctrl;

  typedef struct {
    logic        rst;
    logic        sid;
    logic        sex;
    logic        bf;
    logic [31:0] bt;
    logic        ack;
    logic [31:0] e_pc;
    logic        e_ce;
    logic        e_req;
    logic [5:0]  e_stall;
    logic        e_flush;
  } vec_t;

`ifdef DELAY_SLOT_EN
  localparam logic FlushOn = 1'b0;
`else
  localparam logic FlushOn = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_ack;
  logic [31:0] pc;
  logic        ce;
  logic        inst_req;
  logic [5:0]  stall;
  logic        flush_if;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fetch_ctrl #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .inst_ack      (inst_ack),
    .pc            (pc),
    .ce            (ce),
    .inst_req      (inst_req),
    .stall         (stall),
    .flush_if      (flush_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic sid, input logic sex, input logic bf,
                     input logic [31:0] bt, input logic ack, input logic [31:0] epc,
                     input logic ece, input logic ereq, input logic [5:0] est,
                     input logic efl);
    vec_t v;
    v = '{rst: r, sid: sid, sex: sex, bf: bf, bt: bt, ack: ack, e_pc: epc, e_ce: ece,
          e_req: ereq, e_stall: est, e_flush: efl & FlushOn};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic sid, input logic sex, input logic bf,
                       input logic [31:0] bt, input logic ack);
    rst = r; stallreq_id = sid; stallreq_ex = sex;
    branch_flag = bf; branch_target = bt; inst_ack = ack;
  endtask

  // Inputs change 1 time unit after posedge; outputs sampled at the following negedge.
  task automatic to_sample();
    #4;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    //   rst sid sex bf bt            ack  pc            ce req stall      flush
    add(1, 0, 0, 0, 32'h0,        0,   32'h0,        0, 0, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        0,   32'h0,        0, 0, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h0,        1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h4,        1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h8,        1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'hC,        1, 1, 6'b000000, 0);
    // two wait cycles per fetch
    add(0, 0, 0, 0, 32'h0,        0,   32'h10,       1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        0,   32'h10,       1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h10,       1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        0,   32'h14,       1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        0,   32'h14,       1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h14,       1, 1, 6'b000000, 0);
    // EX stall for 3 cycles with ack held
    add(0, 0, 1, 0, 32'h0,        1,   32'h18,       1, 1, 6'b001111, 0);
    add(0, 0, 1, 0, 32'h0,        1,   32'h18,       1, 1, 6'b001111, 0);
    add(0, 0, 1, 0, 32'h0,        1,   32'h18,       1, 1, 6'b001111, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h18,       1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h1C,       1, 1, 6'b000000, 0);
    // ID stall one cycle
    add(0, 1, 0, 0, 32'h0,        1,   32'h20,       1, 1, 6'b000111, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h20,       1, 1, 6'b000000, 0);
    // reset, then zero-wait branch at pc=8
    add(1, 0, 0, 0, 32'h0,        0,   32'h24,       1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        0,   32'h0,        0, 0, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h0,        1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h4,        1, 1, 6'b000000, 0);
    add(0, 0, 0, 1, 32'h100,      1,   32'h8,        1, 1, 6'b000000, 1);
    add(0, 0, 0, 0, 32'h0,        1,   32'h100,      1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h104,      1, 1, 6'b000000, 0);
    // branch during a 3-cycle wait: latched, applied on ack, then cleared
    add(0, 0, 0, 1, 32'h200,      0,   32'h108,      1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        0,   32'h108,      1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        0,   32'h108,      1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h108,      1, 1, 6'b000000, 1);
    add(0, 0, 0, 0, 32'h0,        1,   32'h200,      1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h204,      1, 1, 6'b000000, 0);
    // branch while stalled is not sampled
    add(0, 0, 1, 1, 32'h300,      1,   32'h208,      1, 1, 6'b001111, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h208,      1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h20C,      1, 1, 6'b000000, 0);
    // second branch overwrites latched target
    add(0, 0, 0, 1, 32'h400,      0,   32'h210,      1, 1, 6'b000011, 0);
    add(0, 0, 0, 1, 32'h500,      0,   32'h210,      1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h210,      1, 1, 6'b000000, 1);
    add(0, 0, 0, 0, 32'h0,        1,   32'h500,      1, 1, 6'b000000, 0);
    // reset mid-WAIT, stale ack ignored, restart
    add(0, 0, 0, 0, 32'h0,        0,   32'h504,      1, 1, 6'b000011, 0);
    add(1, 0, 0, 0, 32'h0,        0,   32'h504,      1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h0,        0, 0, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        0,   32'h0,        1, 1, 6'b000011, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h0,        1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h4,        1, 1, 6'b000000, 0);
    // pc+4 wraps modulo 2^32
    add(0, 0, 0, 1, 32'hFFFF_FFFC, 1,  32'h8,        1, 1, 6'b000000, 1);
    add(0, 0, 0, 0, 32'h0,        1,   32'hFFFF_FFFC, 1, 1, 6'b000000, 0);
    add(0, 0, 0, 0, 32'h0,        1,   32'h0,        1, 1, 6'b000000, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].sid, tbl[i].sex, tbl[i].bf, tbl[i].bt, tbl[i].ack);
      to_sample();
      check($sformatf("v%0d pc", i), pc, tbl[i].e_pc);
      check($sformatf("v%0d ce", i), {31'b0, ce}, {31'b0, tbl[i].e_ce});
      check($sformatf("v%0d inst_req", i), {31'b0, inst_req}, {31'b0, tbl[i].e_req});
      check($sformatf("v%0d stall", i), {26'b0, stall}, {26'b0, tbl[i].e_stall});
      check($sformatf("v%0d flush_if", i), {31'b0, flush_if}, {31'b0, tbl[i].e_flush});
      to_next();
    end

    // 4-cycle ROM latency: pc held at 4 until the ack, then advances to 8
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 32'h0, 0);
      to_sample();
      check($sformatf("lat4 c%0d stall", c), {26'b0, stall}, {26'b0, 6'b000011});
      check($sformatf("lat4 c%0d pc", c), pc, 32'h4);
      to_next();
    end
    drive(0, 0, 0, 0, 32'h0, 1);
    to_sample();
    check("lat4 ack stall", {26'b0, stall}, 32'h0);
    to_next();
    drive(0, 0, 0, 0, 32'h0, 0);
    to_sample();
    check("lat4 pc advanced", pc, 32'h8);

    // priority: EX over ID over fetch-pending
    drive(0, 1, 1, 0, 32'h0, 0);
    #1;
    check("prio ex+id", {26'b0, stall}, {26'b0, 6'b001111});
    drive(0, 1, 0, 0, 32'h0, 0);
    #1;
    check("prio id", {26'b0, stall}, {26'b0, 6'b000111});
    drive(0, 0, 0, 0, 32'h0, 0);
    #1;
    check("prio fetch", {26'b0, stall}, {26'b0, 6'b000011});
    to_next();
    to_sample();
    check("hold ce", {31'b0, ce}, 32'h1);
    check("hold pc", pc, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer and pipeline stall controller for the five-stage core. It owns the program counter and the chip enable of the instruction ROM, and runs a request/acknowledge fetch handshake that tolerates variable ROM latency. It applies branch redirects from ID and produces the 6-bit stall vector consumed by every pipeline register. It replaces the free-running PC register in the IF stage.

## Interface
- `ADDR_W`, default 32: PC width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: core clock; all state changes on the rising edge.
- `rst`  in  1: synchronous reset, active-high (`rst_enable` = 1'b1).
- `stallreq_id`  in  1: ID stage hazard stall request.
- `stallreq_ex`  in  1: EX stage multi-cycle stall request.
- `branch_flag`  in  1: ID has resolved a taken branch or jump this cycle.
- `branch_target`  in  ADDR_W: redirect address, valid with `branch_flag`.
- `inst_ack`  in  1: ROM data valid; held high by the ROM until consumed.
- `pc`  out  ADDR_W: current fetch address.
- `ce`  out  1: ROM chip enable (`chip_enable` / `chip_disable`).
- `inst_req`  out  1: fetch request for `pc`.
- `stall`  out  6: stall vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `flush_if`  out  1: IF/ID register loads a bubble this cycle.

## Operation
- States: IDLE (after reset, ce=0), REQ (first request cycle), WAIT (request outstanding), HOLD (response present, pipeline stalled).
- Reset values: state=IDLE, pc=RESET_PC, ce=0, inst_req=0, redirect_valid=0, stall=0, flush_if=0.
- IDLE→REQ unconditionally on the first clock with rst=0.
- accept = inst_req & inst_ack & ~stallreq_id & ~stallreq_ex.
- REQ/WAIT: inst_req=1. accept stays in REQ with a new pc. inst_ack while stalled → HOLD. No ack → WAIT.
- HOLD: inst_req stays 1 and the ROM holds its data. Moves to REQ on accept.
- On accept: pc ← redirect pending ? target : pc+4. The redirect register then clears.
- PC arithmetic: pc+4 is computed modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
- Stall vector priority: stallreq_ex → 6'b001111. Otherwise stallreq_id → 6'b000111. Otherwise inst_req & ~inst_ack → 6'b000011. Otherwise 6'b000000.
- Redirect capture: branch_flag is sampled only when stallreq_id=0 and stallreq_ex=0.
  - If accept occurs in the same cycle, the target goes straight to pc.
  - Otherwise target is latched with redirect_valid=1.
  - A second branch_flag while redirect_valid=1 overwrites the latched target.
- inst_ack outside REQ/WAIT/HOLD is ignored.
- Reset during WAIT/HOLD aborts the fetch and returns to IDLE. The ROM drops ack on rst.

## Timing
- First request: one cycle after rst deasserts, with ce=1, inst_req=1 and pc=RESET_PC.
- Zero-wait ROM (ack in the request cycle, no stalls): one instruction per cycle, stall=0.
- N wait cycles: stall=6'b000011 for N cycles, then pc advances on the ack cycle.
- Redirect latency: pc=target the cycle after the accept that consumes the redirect.
- flush_if is a single-cycle pulse, aligned with the accept cycle it applies to.

## Configuration
- `DELAY_SLOT_EN` defined: MIPS delay slot. The instruction accepted on or after the branch cycle executes normally, and flush_if is always 0.
- `DELAY_SLOT_EN` undefined: the first instruction accepted on or after the branch cycle is squashed, with flush_if=1 in that accept cycle. The pc sequence is identical in both builds.

## Structure
- defines.vh holds:
  - `rst_enable`, `chip_enable`, `chip_disable`, `zero_v`, `inst_addr_bus`.
  - New stall-vector constants `stall_none`, `stall_fetch`, `stall_id`, `stall_ex`.
  - FSM state encodings.
- One sub-module, `stall_enc`: combinational priority encoder from stallreq_ex, stallreq_id and fetch-pending to the 6-bit stall vector.

## Test plan
- Reset then zero-wait ROM: pc runs 0, 4, 8, 12 on consecutive cycles; ce=1 from the first cycle after reset; stall=0.
- ROM with 2 wait cycles: stall=6'b000011 for 2 cycles per fetch; pc advances every 3 cycles.
- stallreq_ex high for 3 cycles while ack is held: stall=6'b001111, state HOLD, pc frozen; accept and pc+4 on the cycle after stallreq_ex drops.
- branch_flag with target 32'h100 at pc=8, zero-wait:
  - next pc is 32'h100;
  - without `DELAY_SLOT_EN`, flush_if=1 for exactly that cycle;
  - with `DELAY_SLOT_EN`, flush_if stays 0.
- Branch during a 3-cycle ROM wait: target latched; pc=target after the ack; redirect_valid clears.
- rst asserted mid-WAIT: next cycle pc=RESET_PC, ce=0, inst_req=0; a stale ack is ignored; the request restarts one cycle after rst falls.
